// File: rtl/wb_result_queue.sv
// Writeback merge queue: collects up to three execute-unit results per cycle
// (X, Y, M order) into one in-order FIFO and drains one register-file write per cycle.
module wb_result_queue #(
  parameter int DEPTH = 8,
  parameter int SLACK = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [4:0]                   x_wb_regdest,
  input  logic                         x_wb_writereg,
  input  logic [31:0]                  x_wb_wbvalue,
  input  logic [4:0]                   y_wb_regdest,
  input  logic                         y_wb_writereg,
  input  logic [31:0]                  y_wb_wbvalue,
  input  logic [4:0]                   m_wb_regdest,
  input  logic                         m_wb_writereg,
  input  logic [31:0]                  m_wb_wbvalue,
  output logic                         wb_reg_en,
  output logic [4:0]                   wb_reg_addr,
  output logic [31:0]                  wb_reg_data,
  output logic                         wbq_stall,
  output logic [$clog2(DEPTH+1)-1:0]   wbq_count,
  output logic                         wbq_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = CW + 1;
  localparam int NSRC = 3;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] value;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  entry_t          cand_entry [NSRC];
  logic [NSRC-1:0] cand_valid;
  logic [NSRC-1:0] push_en;
  logic [AW-1:0]   push_slot [NSRC];
  logic [1:0]      n_push;
  logic            pop;
  logic            drop_now;
  logic [FW-1:0]   free_slots;

  // Index 0/1/2 is program order X, Y, M; writes to r0 never become candidates.
  always_comb begin
    cand_entry[0] = '{dest: x_wb_regdest, value: x_wb_wbvalue};
    cand_entry[1] = '{dest: y_wb_regdest, value: y_wb_wbvalue};
    cand_entry[2] = '{dest: m_wb_regdest, value: m_wb_wbvalue};
    cand_valid[0] = x_wb_writereg && (x_wb_regdest != 5'd0);
    cand_valid[1] = y_wb_writereg && (y_wb_regdest != 5'd0);
    cand_valid[2] = m_wb_writereg && (m_wb_regdest != 5'd0);
  end

  assign pop        = (wbq_count != '0);
  assign free_slots = FW'(DEPTH) - {1'b0, wbq_count} + {{CW{1'b0}}, pop};

  // NOTE: n_push is a running tally inside one evaluation, so it must use
  // blocking assignments here; registered state elsewhere uses non-blocking.
  always_comb begin
    n_push   = 2'd0;
    drop_now = 1'b0;
    push_en  = '0;
    for (int i = 0; i < NSRC; i++) begin
      push_slot[i] = '0;
      if (cand_valid[i]) begin
        if (FW'(n_push) < free_slots) begin
          push_en[i]   = 1'b1;
          push_slot[i] = tail + AW'(n_push);
          n_push       = n_push + 2'd1;
        end else begin
          drop_now = 1'b1;
        end
      end
    end
  end

  // NOTE: entry storage has no reset; occupancy is tracked by wbq_count, so
  // stale contents are never read and the array maps to plain registers/RAM.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push_en[i]) begin
        mem[push_slot[i]] <= cand_entry[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      wbq_count    <= '0;
      wb_reg_en    <= 1'b0;
      wb_reg_addr  <= '0;
      wb_reg_data  <= '0;
      wbq_overflow <= 1'b0;
    end else begin
      if (pop) begin
        wb_reg_en   <= 1'b1;
        wb_reg_addr <= mem[head].dest;
        wb_reg_data <= mem[head].value;
        head        <= head + AW'(1);
      end else begin
        wb_reg_en <= 1'b0;
      end
      tail      <= tail + AW'(n_push);
      wbq_count <= wbq_count + CW'(n_push) - CW'(pop);
      if (drop_now) begin
        wbq_overflow <= 1'b1;
      end
    end
  end

  // Depends only on the count register so Issue sees no input-to-output path.
  assign wbq_stall = (FW'(DEPTH) - {1'b0, wbq_count}) < FW'(SLACK);

endmodule

// File: tb/tb_wb_result_queue.sv
// Self-checking bench for wb_result_queue: a reference occupancy model feeds a
// scoreboard of expected register-file writes, compared as the DUT drains.
module tb_wb_result_queue;

  localparam int DEPTH = 8;
  localparam int SLACK = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        w;
    logic [4:0]  d;
    logic [31:0] v;
  } res_t;

  logic          clock;
  logic          reset;
  logic [4:0]    x_wb_regdest, y_wb_regdest, m_wb_regdest;
  logic          x_wb_writereg, y_wb_writereg, m_wb_writereg;
  logic [31:0]   x_wb_wbvalue, y_wb_wbvalue, m_wb_wbvalue;
  logic          wb_reg_en;
  logic [4:0]    wb_reg_addr;
  logic [31:0]   wb_reg_data;
  logic          wbq_stall;
  logic [CW-1:0] wbq_count;
  logic          wbq_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [36:0] sb [$];
  int          mc;
  logic        m_ovf;
  logic        m_last_pop;
  logic [31:0] tag;

  wb_result_queue #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clock         (clock),
    .reset         (reset),
    .x_wb_regdest  (x_wb_regdest),
    .x_wb_writereg (x_wb_writereg),
    .x_wb_wbvalue  (x_wb_wbvalue),
    .y_wb_regdest  (y_wb_regdest),
    .y_wb_writereg (y_wb_writereg),
    .y_wb_wbvalue  (y_wb_wbvalue),
    .m_wb_regdest  (m_wb_regdest),
    .m_wb_writereg (m_wb_writereg),
    .m_wb_wbvalue  (m_wb_wbvalue),
    .wb_reg_en     (wb_reg_en),
    .wb_reg_addr   (wb_reg_addr),
    .wb_reg_data   (wb_reg_data),
    .wbq_stall     (wbq_stall),
    .wbq_count     (wbq_count),
    .wbq_overflow  (wbq_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic res_t mk(input logic w, input logic [4:0] d, input logic [31:0] v);
    res_t r;
    r.w = w;
    r.d = d;
    r.v = v;
    return r;
  endfunction

  function automatic res_t none();
    return mk(1'b0, 5'd0, 32'd0);
  endfunction

  task automatic model_clear();
    sb.delete();
    mc         = 0;
    m_ovf      = 1'b0;
    m_last_pop = 1'b0;
  endtask

  // One clock: drive at negedge, model the edge, compare outputs at next negedge.
  task automatic cycle(input res_t x, input res_t y, input res_t m);
    res_t src [3];
    int   free;
    int   n;
    logic p;
    logic [36:0] exp_e;
    src[0] = x; src[1] = y; src[2] = m;
    x_wb_writereg = x.w; x_wb_regdest = x.d; x_wb_wbvalue = x.v;
    y_wb_writereg = y.w; y_wb_regdest = y.d; y_wb_wbvalue = y.v;
    m_wb_writereg = m.w; m_wb_regdest = m.d; m_wb_wbvalue = m.v;
    @(posedge clock);
    p    = (mc > 0);
    free = DEPTH - mc + (p ? 1 : 0);
    n    = 0;
    for (int i = 0; i < 3; i++) begin
      if (src[i].w && src[i].d != 5'd0) begin
        if (n < free) begin
          sb.push_back({src[i].d, src[i].v});
          n++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    mc         = mc + n - (p ? 1 : 0);
    m_last_pop = p;
    @(negedge clock);
    x_wb_writereg = 1'b0; y_wb_writereg = 1'b0; m_wb_writereg = 1'b0;
    checks++;
    if (wb_reg_en !== m_last_pop) begin
      errors++;
      $display("FAIL wb_reg_en: got %b expected %b", wb_reg_en, m_last_pop);
    end
    if (m_last_pop) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: write issued with no expected entry");
      end else begin
        exp_e = sb.pop_front();
        if ({wb_reg_addr, wb_reg_data} !== exp_e) begin
          errors++;
          $display("FAIL write_data: got r%0d=%h expected r%0d=%h",
                   wb_reg_addr, wb_reg_data, exp_e[36:32], exp_e[31:0]);
        end
      end
    end
    checks++;
    if (wbq_count !== CW'(mc)) begin
      errors++;
      $display("FAIL count: got %0d expected %0d", wbq_count, mc);
    end
    checks++;
    if (wbq_stall !== ((DEPTH - mc) < SLACK)) begin
      errors++;
      $display("FAIL stall: got %b expected %b (count %0d)", wbq_stall, (DEPTH - mc) < SLACK, mc);
    end
    checks++;
    if (wbq_overflow !== m_ovf) begin
      errors++;
      $display("FAIL overflow: got %b expected %b", wbq_overflow, m_ovf);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(none(), none(), none());
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (mc != 0 && k < limit) begin
      cycle(none(), none(), none());
      k++;
    end
    idle(1);
    checks++;
    if (wbq_count !== '0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: count %0d, %0d expected writes pending after %0d cycles",
               wbq_count, sb.size(), k);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({wb_reg_en, wb_reg_addr, wb_reg_data, wbq_count, wbq_stall, wbq_overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state: en=%b addr=%0d data=%h count=%0d stall=%b ovf=%b",
               wb_reg_en, wb_reg_addr, wb_reg_data, wbq_count, wbq_stall, wbq_overflow);
    end
  endtask

  task automatic test_single();
    cycle(mk(1'b1, 5'd5, 32'h0000_00AA), none(), none());
    checks++;
    if (wbq_count !== CW'(1) || wb_reg_en !== 1'b0) begin
      errors++;
      $display("FAIL single_edge1: count %0d en %b expected 1/0", wbq_count, wb_reg_en);
    end
    idle(1);
    checks++;
    if (wb_reg_en !== 1'b1 || wb_reg_addr !== 5'd5 || wb_reg_data !== 32'hAA || wbq_count !== '0) begin
      errors++;
      $display("FAIL single_write: en=%b r%0d=%h count=%0d expected 1 r5=000000aa 0",
               wb_reg_en, wb_reg_addr, wb_reg_data, wbq_count);
    end
    idle(1);
    checks++;
    if (wb_reg_en !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle: en=%b expected 0", wb_reg_en);
    end
  endtask

  task automatic test_triple();
    cycle(mk(1'b1, 5'd1, 32'd1), mk(1'b1, 5'd2, 32'd2), mk(1'b1, 5'd3, 32'd3));
    checks++;
    if (wbq_count !== CW'(3)) begin
      errors++;
      $display("FAIL triple_peak: count %0d expected 3", wbq_count);
    end
    drain(10);
  endtask

  task automatic test_r0_discard();
    cycle(mk(1'b1, 5'd0, 32'hDEAD), mk(1'b1, 5'd4, 32'd7), none());
    checks++;
    if (wbq_count !== CW'(1)) begin
      errors++;
      $display("FAIL r0_discard: count %0d expected 1", wbq_count);
    end
    drain(10);
  endtask

  task automatic test_stall();
    for (int c = 0; c < 2; c++)
      cycle(mk(1'b1, 5'd10, 32'h100 + c), mk(1'b1, 5'd11, 32'h200 + c), mk(1'b1, 5'd12, 32'h300 + c));
    checks++;
    if (wbq_count !== CW'(5) || wbq_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_fill: count %0d stall %b expected 5/1", wbq_count, wbq_stall);
    end
    drain(12);
    checks++;
    if (wbq_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: stall %b expected 0", wbq_stall);
    end
  endtask

  task automatic test_back_to_back();
    res_t r [3];
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 3; i++) begin
        tag++;
        // Narrow destination range forces WAW pairs and r0 writes.
        r[i] = mk(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), tag);
      end
      cycle(r[0], r[1], r[2]);
    end
    drain(20);
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 6; c++) begin
      cycle(mk(1'b1, 5'd20, tag + 1), mk(1'b1, 5'd21, tag + 2), mk(1'b1, 5'd22, tag + 3));
      tag = tag + 3;
    end
    checks++;
    if (wbq_count !== CW'(DEPTH) || wbq_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_full: count %0d ovf %b expected %0d/1", wbq_count, wbq_overflow, DEPTH);
    end
    drain(20);
    checks++;
    if (wbq_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf %b expected 1", wbq_overflow);
    end
  endtask

  task automatic test_mid_reset();
    cycle(mk(1'b1, 5'd6, 32'h60), mk(1'b1, 5'd7, 32'h70), mk(1'b1, 5'd8, 32'h80));
    cycle(mk(1'b1, 5'd6, 32'h61), mk(1'b1, 5'd7, 32'h71), mk(1'b1, 5'd8, 32'h81));
    checks++;
    if (wbq_count !== CW'(5)) begin
      errors++;
      $display("FAIL mid_reset_fill: count %0d expected 5", wbq_count);
    end
    #2 reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({wb_reg_en, wb_reg_addr, wb_reg_data, wbq_count, wbq_stall, wbq_overflow} !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: en=%b addr=%0d data=%h count=%0d stall=%b ovf=%b",
               wb_reg_en, wb_reg_addr, wb_reg_data, wbq_count, wbq_stall, wbq_overflow);
    end
    @(negedge clock);
    reset = 1'b1;
    idle(4);
    checks++;
    if (wb_reg_en !== 1'b0 || wbq_count !== '0) begin
      errors++;
      $display("FAIL mid_reset_after: en=%b count=%0d expected 0/0", wb_reg_en, wbq_count);
    end
  endtask

  initial begin
    reset = 1'b0;
    tag   = 32'h1000;
    x_wb_writereg = 1'b0; x_wb_regdest = '0; x_wb_wbvalue = '0;
    y_wb_writereg = 1'b0; y_wb_regdest = '0; y_wb_wbvalue = '0;
    m_wb_writereg = 1'b0; m_wb_regdest = '0; m_wb_wbvalue = '0;
    model_clear();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    test_reset();
    test_single();
    test_triple();
    test_r0_discard();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_result_queue.md
# wb_result_queue

Buffered writeback merge point between the three execute units (X, Y, M) and the Writeback/register-file port. Up to three results arrive per cycle and the register file accepts one write per cycle. The block enqueues accepted results into one shared in-order FIFO and drains one per cycle. It raises a stall toward Issue before the FIFO can overflow. Program order of same-cycle results is fixed (X, then Y, then M), so WAW ordering on the single write port is deterministic.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4
- SLACK, 6, stall asserts when free entries < SLACK; must satisfy 3 ≤ SLACK ≤ DEPTH

Ports:
- clock  in  1  rising-edge clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- x_wb_regdest  in  5  X unit destination register
- x_wb_writereg  in  1  X unit result valid/write request
- x_wb_wbvalue  in  32  X unit result data
- y_wb_regdest / y_wb_writereg / y_wb_wbvalue  in  5/1/32  Y unit, same meaning
- m_wb_regdest / m_wb_writereg / m_wb_wbvalue  in  5/1/32  M unit, same meaning
- wb_reg_en  out  1  register-file write enable, registered
- wb_reg_addr  out  5  register-file write address, registered
- wb_reg_data  out  32  register-file write data, registered
- wbq_stall  out  1  to Issue: stop issuing
- wbq_count  out  $clog2(DEPTH+1)  current occupancy
- wbq_overflow  out  1  sticky error flag: a result was dropped for lack of space

## Operation
- An input is a candidate when its writereg = 1 and its regdest ≠ 0. Writes to r0 are discarded silently and never occupy an entry.
- Candidates are enqueued at the clock edge in the fixed order X, Y, M into consecutive tail slots. An entry is {regdest, wbvalue}.
- Pop: at each edge, if the pre-edge count > 0, the head entry is loaded into wb_reg_addr/wb_reg_data, wb_reg_en ← 1, and the head advances. Otherwise wb_reg_en ← 0 and wb_reg_addr/wb_reg_data hold their values.
- Simultaneous push and pop: next count = count + n_push − pop, where n_push ∈ 0..3 and pop ∈ 0..1. Space check for pushes uses free = DEPTH − count + pop.
- Overflow: if n_push > free, enqueue the first `free` candidates in X, Y, M order, drop the rest, and set wbq_overflow ← 1. The flag clears only on reset.
- wbq_stall = (DEPTH − wbq_count) < SLACK. It is combinational from the count register only and has no input-path dependency.
- Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are decided by count, not by pointer equality.
- No coalescing: two entries for the same regdest both write, in queue order, so the last one wins.

## Timing
- Reset (reset = 0, asynchronous): wb_reg_en = 0, wb_reg_addr = 0, wb_reg_data = 0, wbq_count = 0, wbq_overflow = 0, pointers = 0.
- wbq_stall after reset = 0 when DEPTH ≥ SLACK. Entry storage need not be cleared.
- Reset asserted mid-operation: all queued entries are discarded, and no write is issued on the next edge.
- Latency: a result sampled at edge k into an empty queue drives wb_reg_en = 1 during the cycle after edge k+1. Minimum latency is 2 edges.
- Throughput: one write per cycle. Three same-cycle results appear on consecutive cycles.
- wbq_stall changes one edge after the count crosses the threshold. SLACK must cover results already in flight in the execute pipelines.

## Test plan
- Single X write r5 = 0x0000_00AA at edge 1 → wb_reg_en = 1, addr = 5, data = 0xAA after edge 2 for exactly one cycle; count returns to 0.
- Same edge: X r1 = 1, Y r2 = 2, M r3 = 3 → writes (1,1), (2,2), (3,3) on three consecutive cycles; peak count = 3.
- X writereg = 1 with regdest = 0, plus Y r4 = 7 in the same cycle → only r4 = 7 is written; count peaks at 1.
- With DEPTH = 8 and SLACK = 6, push 3 per cycle for 2 cycles → count reaches 5 after the second push (6 pushed, 1 popped). wbq_stall = 1 once free < 6. Stop inputs → drains in order and wbq_stall deasserts once free ≥ 6.
- Keep 3 pushes per cycle while ignoring stall → count saturates at 8. Excess M (then Y) entries are dropped, wbq_overflow = 1 and stays 1. Every delivered entry is in order, with no duplicates.
- Fill with 5 entries, assert reset = 0 mid-cycle → outputs go to 0 immediately. After release with no input, wb_reg_en stays 0 and count = 0.
